// File: rtl/write_addr_gen.sv
// rtl/write_addr_gen.sv - write-side block address generator for one cache input port
module write_addr_gen #(
  parameter int BLK_ADDR_WIDTH = 10,
  parameter int LEN_WIDTH      = 7
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [LEN_WIDTH-1:0]      i_pkt_len,
  input  logic                      i_pkt_vld,
  output logic                      o_pkt_rdy,
  input  logic                      i_fifo_empty,
  input  logic [BLK_ADDR_WIDTH-1:0] i_free_addr,
  input  logic                      i_free_vld,
  output logic                      o_free_ren,
  output logic [BLK_ADDR_WIDTH-1:0] o_sram_addr,
  output logic                      o_sram_addr_vld,
  output logic [BLK_ADDR_WIDTH-1:0] o_link_addr,
  output logic [BLK_ADDR_WIDTH-1:0] o_link_next,
  output logic                      o_link_vld,
  output logic [BLK_ADDR_WIDTH-1:0] o_desc_head,
  output logic [BLK_ADDR_WIDTH-1:0] o_desc_tail,
  output logic [LEN_WIDTH-1:0]      o_desc_len,
  output logic                      o_desc_vld,
  input  logic                      i_desc_rdy,
  output logic                      o_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DESC  = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;

  logic [LEN_WIDTH-1:0]        r_len;
  logic [LEN_WIDTH-1:0]        r_cnt;
  logic [BLK_ADDR_WIDTH-1:0]   r_head;
  logic [BLK_ADDR_WIDTH-1:0]   r_prev;
  logic [BLK_ADDR_WIDTH-1:0]   r_tail;
  logic [BLK_ADDR_WIDTH-1:0]   r_link_addr;
  logic [BLK_ADDR_WIDTH-1:0]   r_link_next;
  logic                        r_link_vld;
  logic                        r_err;

  logic                        w_accept;
  logic                        w_len_zero;
  logic                        w_fire;
  logic                        w_last;
  logic                        w_first;
  logic                        w_desc_on;

  // Reset forces every output low in the same cycle, so all strobes are gated by i_rst.
  assign w_accept   = (r_state == S_IDLE) && i_pkt_vld && !i_rst;
  assign w_len_zero = (i_pkt_len == '0);
  assign w_fire     = (r_state == S_WRITE) && i_free_vld && !i_fifo_empty && !i_rst;
  assign w_first    = (r_cnt == '0);
  assign w_last     = w_fire && (r_cnt == (r_len - LEN_WIDTH'(1)));
  assign w_desc_on  = (r_state == S_DESC) && !i_rst;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: zero-length descriptors are dropped without leaving IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_len_zero) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_state_nxt = S_DESC;
        end
      end
      S_DESC: begin
        if (i_desc_rdy) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Packet bookkeeping: length, word counter and the head/previous/tail blocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len  <= '0;
      r_cnt  <= '0;
      r_head <= '0;
      r_prev <= '0;
      r_tail <= '0;
    end else begin
      if (w_accept && !w_len_zero) begin
        r_len <= i_pkt_len;
        r_cnt <= '0;
      end
      if (w_fire) begin
        r_cnt  <= r_cnt + LEN_WIDTH'(1);
        r_prev <= i_free_addr;
        if (w_first) begin
          r_head <= i_free_addr;
        end
        if (w_last) begin
          r_tail <= i_free_addr;
        end
      end
    end
  end

  // Link writes chain each non-first block to its predecessor; error pulse for dropped descriptors.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_link_vld  <= 1'b0;
      r_link_addr <= '0;
      r_link_next <= '0;
      r_err       <= 1'b0;
    end else begin
      r_link_vld <= w_fire && !w_first;
      if (w_fire && !w_first) begin
        r_link_addr <= r_prev;
        r_link_next <= i_free_addr;
      end
      r_err <= w_accept && w_len_zero;
    end
  end

  assign o_pkt_rdy       = (r_state == S_IDLE) && !i_rst;
  assign o_free_ren      = w_fire;
  assign o_sram_addr_vld = w_fire;
  assign o_sram_addr     = w_fire ? i_free_addr : '0;

  assign o_link_vld      = r_link_vld && !i_rst;
  assign o_link_addr     = i_rst ? '0 : r_link_addr;
  assign o_link_next     = i_rst ? '0 : r_link_next;

  assign o_desc_vld      = w_desc_on;
  assign o_desc_head     = w_desc_on ? r_head : '0;
  assign o_desc_tail     = w_desc_on ? r_tail : '0;
  assign o_desc_len      = w_desc_on ? r_len  : '0;

  assign o_err           = r_err && !i_rst;

endmodule

// File: tb/tb_write_addr_gen.sv
// tb/tb_write_addr_gen.sv - self-checking bench for write_addr_gen
module tb_write_addr_gen;

  localparam int AW = 10;
  localparam int LW = 7;

  logic          i_clk;
  logic          i_rst;
  logic [LW-1:0] i_pkt_len;
  logic          i_pkt_vld;
  logic          o_pkt_rdy;
  logic          i_fifo_empty;
  logic [AW-1:0] i_free_addr;
  logic          i_free_vld;
  logic          o_free_ren;
  logic [AW-1:0] o_sram_addr;
  logic          o_sram_addr_vld;
  logic [AW-1:0] o_link_addr;
  logic [AW-1:0] o_link_next;
  logic          o_link_vld;
  logic [AW-1:0] o_desc_head;
  logic [AW-1:0] o_desc_tail;
  logic [LW-1:0] o_desc_len;
  logic          o_desc_vld;
  logic          i_desc_rdy;
  logic          o_err;

  write_addr_gen #(.BLK_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pkt_len(i_pkt_len), .i_pkt_vld(i_pkt_vld), .o_pkt_rdy(o_pkt_rdy),
    .i_fifo_empty(i_fifo_empty),
    .i_free_addr(i_free_addr), .i_free_vld(i_free_vld), .o_free_ren(o_free_ren),
    .o_sram_addr(o_sram_addr), .o_sram_addr_vld(o_sram_addr_vld),
    .o_link_addr(o_link_addr), .o_link_next(o_link_next), .o_link_vld(o_link_vld),
    .o_desc_head(o_desc_head), .o_desc_tail(o_desc_tail), .o_desc_len(o_desc_len),
    .o_desc_vld(o_desc_vld), .i_desc_rdy(i_desc_rdy), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Pool contents offered to the DUT, head first.
  logic [AW-1:0] pool_q[$];
  bit            pool_en = 1'b1;
  bit            ren_seen = 1'b0;

  // Packet-level model: phase 0 waiting for a descriptor, 1 collecting blocks, 2 reporting.
  int            m_ph = 0;
  int            m_len = 0;
  logic [AW-1:0] m_words[$];
  bit            m_lv = 1'b0;
  logic [AW-1:0] m_la = '0;
  logic [AW-1:0] m_ln = '0;
  bit            m_err = 1'b0;
  int            acc_cnt = 0;

  // Observation logs for literal checks.
  logic [AW-1:0]   issue_log[$];
  int              issue_cyc[$];
  logic [2*AW-1:0] link_log[$];
  logic [2*AW+LW-1:0] desc_log[$];
  int  err_cnt = 0;
  int  rdy_low_cnt = 0;
  int  cyc = 0;
  int  last_issue_cyc = 0;
  int  rdy_rise_cyc = 0;
  bit  prev_dv = 1'b0;
  bit  prev_rdy = 1'b0;

  // Compare DUT against the model mid-cycle, then advance the model with this cycle's inputs.
  always @(negedge i_clk) begin : cmp
    bit ef;
    bit ed;
    cyc++;
    ef = !i_rst && (m_ph == 1) && i_free_vld && !i_fifo_empty;
    ed = !i_rst && (m_ph == 2);
    chk("pkt_rdy", o_pkt_rdy, !i_rst && (m_ph == 0));
    chk("sram_vld", o_sram_addr_vld, ef);
    chk("free_ren", o_free_ren, ef);
    if (ef) chk("sram_addr", o_sram_addr, i_free_addr);
    if (i_rst) chk("sram_addr_rst", o_sram_addr, 0);
    chk("link_vld", o_link_vld, m_lv && !i_rst);
    if (m_lv && !i_rst) begin
      chk("link_addr", o_link_addr, m_la);
      chk("link_next", o_link_next, m_ln);
    end
    if (i_rst) begin
      chk("link_addr_rst", o_link_addr, 0);
      chk("link_next_rst", o_link_next, 0);
    end
    chk("err", o_err, m_err && !i_rst);
    chk("desc_vld", o_desc_vld, ed);
    if (ed) begin
      chk("desc_head", o_desc_head, m_words[0]);
      chk("desc_tail", o_desc_tail, m_words[m_words.size()-1]);
      chk("desc_len", o_desc_len, m_len);
    end else begin
      chk("desc_fields_idle", {o_desc_head, o_desc_tail, o_desc_len}, 0);
    end

    if (o_sram_addr_vld) begin
      issue_log.push_back(o_sram_addr);
      issue_cyc.push_back(cyc);
      last_issue_cyc = cyc;
    end
    if (o_link_vld) link_log.push_back({o_link_addr, o_link_next});
    if (o_desc_vld && !prev_dv) desc_log.push_back({o_desc_head, o_desc_tail, o_desc_len});
    if (o_err) err_cnt++;
    if (!o_pkt_rdy && !i_rst) rdy_low_cnt++;
    if (o_pkt_rdy && !prev_rdy) rdy_rise_cyc = cyc;
    prev_dv  = o_desc_vld;
    prev_rdy = o_pkt_rdy;
    ren_seen = o_free_ren;

    if (i_rst) begin
      m_ph = 0; m_lv = 1'b0; m_err = 1'b0;
      m_words.delete();
    end else begin
      m_lv = 1'b0; m_err = 1'b0;
      if (m_ph == 0) begin
        if (i_pkt_vld) begin
          acc_cnt++;
          if (i_pkt_len == 0) m_err = 1'b1;
          else begin
            m_ph = 1; m_len = int'(i_pkt_len);
            m_words.delete();
          end
        end
      end else if (m_ph == 1) begin
        if (ef) begin
          if (m_words.size() > 0) begin
            m_lv = 1'b1;
            m_la = m_words[m_words.size()-1];
            m_ln = i_free_addr;
          end
          m_words.push_back(i_free_addr);
          if (m_words.size() == m_len) m_ph = 2;
        end
      end else if (i_desc_rdy) begin
        m_ph = 0;
      end
    end
  end

  task automatic drive_pool();
    i_free_vld  = pool_en && (pool_q.size() > 0);
    i_free_addr = (pool_q.size() > 0) ? pool_q[0] : 10'h3FF;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    if (ren_seen && pool_q.size() > 0) void'(pool_q.pop_front());
    drive_pool();
  endtask

  task automatic clr_logs();
    issue_log.delete(); issue_cyc.delete(); link_log.delete(); desc_log.delete();
    err_cnt = 0; rdy_low_cnt = 0;
  endtask

  task automatic fill_pool(input int base, input int n);
    pool_q.delete();
    for (int i = 0; i < n; i++) pool_q.push_back(AW'(base + i));
    drive_pool();
  endtask

  task automatic send(input int len);
    int a;
    int n;
    a = acc_cnt; n = 0;
    i_pkt_len = LW'(len);
    i_pkt_vld = 1'b1;
    while (acc_cnt == a && n < 600) begin tick(); n++; end
    chk("accept_timeout", acc_cnt != a, 1);
    i_pkt_vld = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (m_ph != 0 && n < 600) begin tick(); n++; end
    chk("done_timeout", m_ph == 0, 1);
    tick(); tick();
  endtask

  initial begin
    logic [2*AW+LW-1:0] held;
    int a;
    int n;
    i_rst = 1'b1; i_pkt_len = '0; i_pkt_vld = 1'b0; i_fifo_empty = 1'b0;
    i_desc_rdy = 1'b1; pool_en = 1'b1;
    drive_pool();
    tick(); tick();
    i_rst = 1'b0;
    tick();

    // Length 4, no stalls.
    clr_logs();
    fill_pool(16, 4);
    send(4);
    wait_done();
    chk("t1_issues", issue_log.size(), 4);
    chk("t1_a0", issue_log[0], 10'h010);
    chk("t1_a3", issue_log[3], 10'h013);
    chk("t1_back2back", issue_cyc[3] - issue_cyc[0], 3);
    chk("t1_links", link_log.size(), 3);
    chk("t1_l0", link_log[0], {10'h010, 10'h011});
    chk("t1_l2", link_log[2], {10'h012, 10'h013});
    chk("t1_desc", desc_log[0], {10'h010, 10'h013, 7'd4});
    chk("t1_rdy_lat", rdy_rise_cyc - last_issue_cyc, 2);

    // Length 1.
    clr_logs();
    fill_pool(10'h2A5, 1);
    send(1);
    wait_done();
    chk("t2_issues", issue_log.size(), 1);
    chk("t2_links", link_log.size(), 0);
    chk("t2_desc", desc_log[0], {10'h2A5, 10'h2A5, 7'd1});

    // Length 0 is dropped with an error pulse.
    clr_logs();
    fill_pool(64, 2);
    send(0);
    tick(); tick(); tick();
    chk("t3_err", err_cnt, 1);
    chk("t3_issues", issue_log.size(), 0);
    chk("t3_descs", desc_log.size(), 0);
    chk("t3_rdy_low", rdy_low_cnt, 0);

    // Length 3 with FIFO-empty then pool-empty stalls.
    clr_logs();
    fill_pool(10'h030, 3);
    send(3);
    tick();
    i_fifo_empty = 1'b1;
    tick(); tick();
    i_fifo_empty = 1'b0; pool_en = 1'b0; drive_pool();
    tick();
    pool_en = 1'b1; drive_pool();
    wait_done();
    chk("t4_issues", issue_log.size(), 3);
    chk("t4_gap", issue_cyc[1] - issue_cyc[0], 4);
    chk("t4_gap2", issue_cyc[2] - issue_cyc[1], 1);
    chk("t4_desc", desc_log[0], {10'h030, 10'h032, 7'd3});

    // Length 5 held in descriptor phase; a queued descriptor waits for the handshake.
    clr_logs();
    fill_pool(10'h200, 7);
    i_desc_rdy = 1'b0;
    send(5);
    n = 0;
    while (m_ph != 2 && n < 100) begin tick(); n++; end
    i_pkt_len = 7'd2; i_pkt_vld = 1'b1;
    a = acc_cnt;
    held = {o_desc_head, o_desc_tail, o_desc_len};
    chk("t5_held0", held, {10'h200, 10'h204, 7'd5});
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t5_stable", {o_desc_head, o_desc_tail, o_desc_len}, held);
      chk("t5_vld_held", o_desc_vld, 1);
    end
    chk("t5_no_accept", acc_cnt - a, 0);
    i_desc_rdy = 1'b1;
    n = 0;
    while (acc_cnt == a && n < 50) begin tick(); n++; end
    chk("t5_accept_after", acc_cnt - a, 1);
    i_pkt_vld = 1'b0;
    wait_done();
    chk("t5_descs", desc_log.size(), 2);
    chk("t5_desc2", desc_log[1], {10'h205, 10'h206, 7'd2});

    // Reset after the 2nd word of a length-6 packet, then a fresh length-2 packet.
    clr_logs();
    fill_pool(10'h100, 8);
    send(6);
    tick(); tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("t6_after_rst", {o_sram_addr_vld, o_link_vld, o_desc_vld, o_err, o_free_ren}, 0);
    tick();
    send(2);
    wait_done();
    chk("t6_issues", issue_log.size(), 4);
    chk("t6_links", link_log.size(), 1);
    chk("t6_l0", link_log[0], {10'h102, 10'h103});
    chk("t6_descs", desc_log.size(), 1);
    chk("t6_desc", desc_log[0], {10'h102, 10'h103, 7'd2});

    // Maximum length.
    clr_logs();
    fill_pool(300, 127);
    send(127);
    wait_done();
    chk("t7_issues", issue_log.size(), 127);
    chk("t7_links", link_log.size(), 126);
    chk("t7_desc", desc_log[0], {10'd300, 10'd426, 7'd127});

    // Randomized traffic with stalls, back-pressure and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      while (pool_q.size() < 8) pool_q.push_back(AW'($urandom_range(0, 1023)));
      i_fifo_empty = ($urandom % 4) == 0;
      pool_en      = ($urandom % 5) != 0;
      i_desc_rdy   = ($urandom % 3) != 0;
      i_rst        = ($urandom % 300) == 0;
      if (!i_pkt_vld && ($urandom % 3) == 0) begin
        i_pkt_vld = 1'b1;
        i_pkt_len = (($urandom % 8) == 0) ? 7'd0 : LW'($urandom_range(1, 12));
      end
      drive_pool();
      a = acc_cnt;
      tick();
      if (acc_cnt != a) i_pkt_vld = 1'b0;
    end
    i_rst = 1'b0; i_pkt_vld = 1'b0; i_fifo_empty = 1'b0; pool_en = 1'b1; i_desc_rdy = 1'b1;
    while (pool_q.size() < 16) pool_q.push_back(AW'($urandom_range(0, 1023)));
    drive_pool();
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
